pwm_fade_sequencer: RTL

Sequences the PWM duty-cycle value between the SPI register file and the PWM peripheral. When a new duty target is written, the block ramps its `duty_out` toward the target in fixed steps at a programmable rate, which gives soft-start and fade behaviour. It can also apply the target immediately. It sits in the top level: the SPI duty register and write strobe feed its inputs, and `duty_out` drives the PWM peripheral's `pwm_duty_cycle`.

---
 rtl/pwm_fade_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
// Sits between the SPI duty register and the PWM peripheral. A new duty target
// is either applied at once or reached by ramping duty_out_o in fixed steps at a
// programmable rate, giving soft-start and fade behaviour.
//
// Build option: define PWM_FADE_SEQUENCER_EN to include the ramp engine.
// Without it every accepted target is applied immediately, the fade controls
// are ignored and busy_o is tied low.
module pwm_fade_sequencer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [7:0]          target_duty_i,
  input  logic                target_valid_i,
  input  logic [7:0]          step_size_i,
  input  logic [PERIOD_W-1:0] step_period_i,
  input  logic                fade_en_i,
  output logic [7:0]          duty_out_o,
  output logic                busy_o,
  output logic                done_o
);

`ifdef PWM_FADE_SEQUENCER_EN

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          tgt_q, tgt_d;
  logic [7:0]          stp_q, stp_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] tick_q, tick_d;
  logic [7:0]          duty_q, duty_d;
  logic                done_q, done_d;

  logic [7:0]          eff_step;
  logic [PERIOD_W-1:0] eff_period;
  logic [8:0]          up_sum;
  logic [8:0]          dn_diff;
  logic [7:0]          up_next;
  logic [7:0]          dn_next;
  logic                step_now;

  // Zero step size or period would stall the ramp, so both are promoted to 1.
  always_comb begin
    eff_step   = (step_size_i == 8'd0) ? 8'd1 : step_size_i;
    eff_period = (step_period_i == '0) ? PERIOD_W'(1) : step_period_i;
  end

  // Candidate next duty values, 9-bit so a step can never wrap, clamped to tgt.
  always_comb begin
    up_sum   = {1'b0, duty_q} + {1'b0, stp_q};
    dn_diff  = {1'b0, duty_q} - {1'b0, stp_q};
    up_next  = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[7:0];
    dn_next  = (dn_diff[8] || (dn_diff[7:0] < tgt_q)) ? tgt_q : dn_diff[7:0];
    step_now = (tick_q == (per_q - PERIOD_W'(1)));
  end

  // Accept/dispatch and ramp stepping; an accept always overrides a step.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    per_d   = per_q;
    tick_d  = tick_q;
    duty_d  = duty_q;
    done_d  = 1'b0;

    if (target_valid_i) begin
      tgt_d  = target_duty_i;
      stp_d  = eff_step;
      per_d  = eff_period;
      tick_d = '0;
      if (!fade_en_i || (target_duty_i == duty_q)) begin
        duty_d  = target_duty_i;
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (target_duty_i > duty_q) begin
        state_d = RAMP_UP;
      end else begin
        state_d = RAMP_DOWN;
      end
    end else begin
      case (state_q)
        RAMP_UP: begin
          if (step_now) begin
            tick_d = '0;
            duty_d = up_next;
            if (up_next == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            tick_d = tick_q + PERIOD_W'(1);
          end
        end
        RAMP_DOWN: begin
          if (step_now) begin
            tick_d = '0;
            duty_d = dn_next;
            if (dn_next == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            tick_d = tick_q + PERIOD_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tgt_q   <= 8'd0;
      stp_q   <= 8'd1;
      per_q   <= PERIOD_W'(1);
      tick_q  <= '0;
      duty_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

  assign duty_out_o = duty_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

`else

  logic [7:0] duty_q, duty_d;
  logic       done_q, done_d;
  logic       unused_cfg;

  // The fade controls have no effect in this build.
  assign unused_cfg = ^{fade_en_i, step_size_i, step_period_i};

  // Every accepted target is applied directly with a done pulse.
  always_comb begin
    duty_d = duty_q;
    done_d = 1'b0;
    if (target_valid_i) begin
      duty_d = target_duty_i;
      done_d = 1'b1;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q <= 8'd0;
      done_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      done_q <= done_d;
    end
  end

  assign duty_out_o = duty_q;
  assign busy_o     = 1'b0;
  assign done_o     = done_q;

`endif

endmodule
